// File: rtl/rr_arbiter4_pkg.sv
// Shared types and constants for the 4-way round-robin / fixed-priority arbiter.
package rr_arbiter4_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned ID_W  = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_t;

  // Registered status presented to the requesters and the datapath select mux
  typedef struct packed {
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             gs;
    logic             idle;
    logic             timeout;
  } arb_status_t;

  localparam arb_status_t STATUS_IDLE = '{
    grant:    '0,
    grant_id: '0,
    gs:       1'b0,
    idle:     1'b1,
    timeout:  1'b0
  };

  function automatic logic [N_REQ-1:0] id2onehot(input logic [ID_W-1:0] id);
    return N_REQ'(1) << id;
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the requester blocks and the arbiter.
interface rr_arbiter4_if;
  import rr_arbiter4_pkg::*;

  logic             en;
  logic             mode;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             gs;
  logic             idle;
  logic             timeout;

  modport master (
    output en, mode, req,
    input  grant, grant_id, gs, idle, timeout
  );

  modport slave (
    input  en, mode, req,
    output grant, grant_id, gs, idle, timeout
  );

endinterface

// File: rtl/rr_pick4.sv
// Combinational winner select: highest index (fixed) or first set bit from start (round-robin).
module rr_pick4
  import rr_arbiter4_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  start,
  input  logic             rr,
  output logic [ID_W-1:0]  id,
  output logic             valid
);

  logic [ID_W-1:0] idx;

  always_comb begin
    id    = '0;
    idx   = '0;
    valid = |req;
    if (rr) begin
      // Walk farthest-to-nearest so the nearest set bit after start wins last
      for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
        idx = start + ID_W'(k);
        if (req[idx]) id = idx;
      end
    end else begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (req[i]) id = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester arbiter: non-preemptive ownership with a hold timeout and a dead cycle between owners.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter4_if.slave  bus
);

  localparam int unsigned   CW        = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  state_t          state;
  logic [CW-1:0]   hold_cnt;
  logic [ID_W-1:0] last;
  arb_status_t     st;

  logic [ID_W-1:0] start_c;
  logic            rr_c;
  logic [ID_W-1:0] pick_id_c;
  logic            pick_valid_c;

  assign start_c = last + ID_W'(1);
  assign rr_c    = (mode_t'(bus.mode) == MODE_RR);

  rr_pick4 u_pick (
    .req   (bus.req),
    .start (start_c),
    .rr    (rr_c),
    .id    (pick_id_c),
    .valid (pick_valid_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      last     <= ID_W'(N_REQ - 1);
      st       <= STATUS_IDLE;
    end else begin
      st.timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.en && pick_valid_c) begin
            state       <= ST_OWN;
            hold_cnt    <= '0;
            last        <= pick_id_c;
            st.grant    <= id2onehot(pick_id_c);
            st.grant_id <= pick_id_c;
            st.gs       <= 1'b1;
            st.idle     <= 1'b0;
          end
        end
        ST_OWN: begin
          // Release takes precedence; expiry only revokes a still-requesting owner
          if (!bus.req[st.grant_id] || (hold_cnt == HOLD_LAST)) begin
            state      <= ST_IDLE;
            hold_cnt   <= '0;
            st         <= STATUS_IDLE;
            st.timeout <= bus.req[st.grant_id];
          end else begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          hold_cnt <= '0;
          st       <= STATUS_IDLE;
        end
      endcase
    end
  end

  assign bus.grant    = st.grant;
  assign bus.grant_id = st.grant_id;
  assign bus.gs       = st.gs;
  assign bus.idle     = st.idle;
  assign bus.timeout  = st.timeout;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: directed vector table, hand sequences, random vs reference model.
module tb_rr_arbiter4;

  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  rr_arbiter4_if bus();

  rr_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: owner index (-1 = none) and number of cycles granted so far
  int   m_owner = -1;
  int   m_held  = 0;
  int   m_last  = 3;
  logic m_to    = 1'b0;

  function automatic int pick(input logic [3:0] r, input logic rr, input int lst);
    int w;
    w = -1;
    if (rr) begin
      for (int k = 4; k >= 1; k--) if (r[(lst + k) % 4]) w = (lst + k) % 4;
    end else begin
      for (int i = 0; i < 4; i++) if (r[i]) w = i;
    end
    return w;
  endfunction

  function automatic void model_step();
    m_to = 1'b0;
    if (rst) begin
      m_owner = -1;
      m_held  = 0;
      m_last  = 3;
    end else if (m_owner < 0) begin
      if (bus.en && bus.req != 4'b0000) begin
        m_owner = pick(bus.req, bus.mode, m_last);
        m_last  = m_owner;
        m_held  = 1;
      end
    end else if (!bus.req[m_owner]) begin
      m_owner = -1;
    end else if (m_held == MAX_HOLD) begin
      m_owner = -1;
      m_to    = 1'b1;
    end else begin
      m_held++;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] eg, input logic [1:0] eid, input logic eto);
    logic [8:0] act;
    logic [8:0] exp;
    act = {bus.grant, bus.grant_id, bus.gs, bus.idle, bus.timeout};
    exp = {eg, eid, |eg, (eg == 4'b0000), eto};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t: got grant=%b id=%0d gs=%b idle=%b timeout=%b, want grant=%b id=%0d gs=%b idle=%b timeout=%b",
               nm, $time, bus.grant, bus.grant_id, bus.gs, bus.idle, bus.timeout,
               eg, eid, |eg, (eg == 4'b0000), eto);
    end
  endtask

  task automatic chk_model(input string nm);
    logic [3:0] eg;
    logic [1:0] eid;
    eg  = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    eid = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    chk(nm, eg, eid, m_to);
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic       mode;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] id;
    logic       to;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic e, input logic m, input logic [3:0] q,
                              input logic [3:0] g, input logic [1:0] i, input logic t);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.req = q; v.grant = g; v.id = i; v.to = t;
    return v;
  endfunction

  task automatic drive(input logic r, input logic e, input logic m, input logic [3:0] q);
    rst = r; bus.en = e; bus.mode = m; bus.req = q;
  endtask

  initial begin
    drive(1'b1, 1'b1, 1'b0, 4'b1111);

    // rst en mode req | grant id timeout
    vecs.push_back(mk(1, 1, 0, 4'b1111, 4'b0000, 0, 0));
    vecs.push_back(mk(1, 1, 0, 4'b1111, 4'b0000, 0, 0));
    vecs.push_back(mk(1, 1, 0, 4'b1111, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 4'b1000, 3, 0));
    vecs.push_back(mk(0, 1, 0, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'b0100, 4'b0100, 2, 0));
    vecs.push_back(mk(0, 1, 0, 4'b0100, 4'b0100, 2, 0));
    vecs.push_back(mk(0, 1, 0, 4'b0100, 4'b0100, 2, 0));
    vecs.push_back(mk(0, 1, 0, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'b0100, 4'b0100, 2, 0));
    vecs.push_back(mk(0, 1, 0, 4'b0001, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'b0001, 4'b0001, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0010, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0010, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'b0010, 4'b0010, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0010, 4'b0010, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'b0100, 4'b0100, 2, 0));
    vecs.push_back(mk(1, 1, 1, 4'b1111, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'b1111, 4'b0001, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'b0011, 4'b0010, 1, 0));
    vecs.push_back(mk(0, 1, 1, 4'b0011, 4'b0010, 1, 0));
    vecs.push_back(mk(0, 1, 1, 4'b0001, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'b0011, 4'b0001, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'b0000, 4'b0000, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].req);
      step();
      chk($sformatf("vec%0d", i), vecs[i].grant, vecs[i].id, vecs[i].to);
    end

    // Owner holding exactly MAX_HOLD cycles then releasing: no timeout
    drive(0, 1, 0, 4'b0001);
    for (int c = 0; c < MAX_HOLD; c++) begin
      step();
      chk("hold_exact", 4'b0001, 2'd0, 1'b0);
    end
    drive(0, 1, 0, 4'b0000);
    step();
    chk("hold_exact_release", 4'b0000, 2'd0, 1'b0);

    // Round-robin rotation with timeouts, starting fresh from reset
    drive(1, 1, 1, 4'b0000);
    step();
    drive(0, 1, 1, 4'b1111);
    for (int o = 0; o < 5; o++) begin
      for (int c = 0; c < MAX_HOLD; c++) begin
        step();
        chk("rr_own", 4'b0001 << (o % 4), 2'(o % 4), 1'b0);
      end
      step();
      chk("rr_timeout", 4'b0000, 2'd0, 1'b1);
    end

    // Fixed-priority starvation: index 3 re-granted after every timeout
    drive(1, 1, 0, 4'b0000);
    step();
    drive(0, 1, 0, 4'b1011);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < MAX_HOLD; c++) begin
        step();
        chk("fixed_own", 4'b1000, 2'd3, 1'b0);
      end
      step();
      chk("fixed_timeout", 4'b0000, 2'd0, 1'b1);
    end

    // Randomized traffic against the reference model
    drive(1, 1, 0, 4'b0000);
    step();
    chk_model("rand_reset");
    for (int n = 0; n < 4000; n++) begin
      logic [3:0] q;
      q = bus.req;
      for (int b = 0; b < 4; b++) if ($urandom_range(5) == 0) q[b] = ~q[b];
      drive(($urandom_range(99) == 0), ($urandom_range(7) != 0),
            (($urandom_range(15) == 0) ? ~bus.mode : bus.mode), q);
      step();
      chk_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
